// File: rtl/iddmm_res_collect.sv
// Result collector for the IDDMM multiplier: captures streamed N x K-bit results into a
// two-bank ping-pong buffer and replays them over a valid/ready stream.

module iddmm_res_bank #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [K-1:0]      wr_data,
  input  logic              wr_close,
  input  logic              drain_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [K-1:0]      rd_data,
  output logic              full,
  output logic [ADDR_W-1:0] last_idx
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_e;

  bank_st_e          st_q, st_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [K-1:0]      mem_q [N];

  // Write and drain never target the same bank in one cycle: writes need !FULL, drains need FULL.
  always_comb begin
    st_d   = st_q;
    last_d = last_q;
    if (clr) begin
      st_d = B_EMPTY;
    end else begin
      if (drain_done) st_d = B_EMPTY;
      if (wr_en) begin
        st_d = wr_close ? B_FULL : B_FILLING;
        if (wr_close) last_d = wr_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= B_EMPTY;
      last_q <= '0;
    end else begin
      st_q   <= st_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data  = mem_q[rd_addr];
  assign full     = (st_q == B_FULL);
  assign last_idx = last_q;

endmodule

module iddmm_res_collect #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [K-1:0]      in_data,
  input  logic              in_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [K-1:0]      res_data,
  output logic [ADDR_W-1:0] res_idx,
  output logic              res_last,
  output logic [1:0]        bank_full,
  output logic              err_ovf,
  output logic              err_len
);

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              drop_q, drop_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_len_q, err_len_d;

  logic [1:0]             wr_en, drain_done, full_b;
  logic [1:0][K-1:0]      rd_data_b;
  logic [1:0][ADDR_W-1:0] last_idx_b;

  logic blocked, accept, at_end, close, vld, last, hs;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    iddmm_res_bank #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .wr_en      (wr_en[b]),
      .wr_addr    (wr_ptr_q),
      .wr_data    (in_data),
      .wr_close   (close),
      .drain_done (drain_done[b]),
      .rd_addr    (rd_ptr_q),
      .rd_data    (rd_data_b[b]),
      .full       (full_b[b]),
      .last_idx   (last_idx_b[b])
    );
  end

  // Drop mode persists until the in_last of the rejected result so results never interleave.
  always_comb begin
    blocked = in_valid & (drop_q | full_b[wr_bank_q]);
    accept  = in_valid & ~blocked;
    at_end  = (wr_ptr_q == ADDR_W'(N - 1));
    close   = accept & (in_last | at_end);
    vld     = full_b[rd_bank_q];
    last    = vld & (rd_ptr_q == last_idx_b[rd_bank_q]);
    hs      = vld & res_ready;
  end

  always_comb begin
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_d     = drop_q;
    err_ovf_d  = err_ovf_q;
    err_len_d  = err_len_q;
    wr_en      = '0;
    drain_done = '0;
    if (clr) begin
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      drop_d    = 1'b0;
      err_ovf_d = 1'b0;
      err_len_d = 1'b0;
    end else begin
      if (blocked) begin
        err_ovf_d = 1'b1;
        drop_d    = ~in_last;
      end
      if (accept) begin
        wr_en[wr_bank_q] = 1'b1;
        wr_ptr_d         = close ? '0 : ADDR_W'(wr_ptr_q + 1'b1);
        if (close) begin
          wr_bank_d = ~wr_bank_q;
          if (in_last != at_end) err_len_d = 1'b1;
        end
      end
      if (hs) begin
        if (last) begin
          drain_done[rd_bank_q] = 1'b1;
          rd_bank_d             = ~rd_bank_q;
          rd_ptr_d              = '0;
        end else begin
          rd_ptr_d = ADDR_W'(rd_ptr_q + 1'b1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      drop_q    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      drop_q    <= drop_d;
      err_ovf_q <= err_ovf_d;
      err_len_q <= err_len_d;
    end
  end

  assign res_valid = vld;
  assign res_data  = vld ? rd_data_b[rd_bank_q] : '0;
  assign res_idx   = vld ? rd_ptr_q : '0;
  assign res_last  = last;
  assign bank_full = full_b;
  assign err_ovf   = err_ovf_q;
  assign err_len   = err_len_q;

endmodule
